// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter conditional-branch predictor.
// Predicts the ID branch combinationally, resolves it one cycle later in EX,
// flags mispredictions with the recovery PC and trains the counter table.
// Optional feature macro: BP_GSHARE_EN (XORs a global history register into
// the table index; without it the index is plain PC bits).
module branch_predictor #(
   parameter int         IDX_BITS   = 4,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        branchID,
   input  logic [31:0] pcID,
   input  logic        advance,
   input  logic        flush,
   input  logic        actualEX,
   input  logic [31:0] targetEX,
   output logic        taken,
   output logic        needFlush,
   output logic [31:0] recoverPC
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [1:0]          counters [ENTRIES];
   logic [IDX_BITS-1:0] pc_idx;
   logic [IDX_BITS-1:0] lookup_idx;

   logic                pend_valid;
   logic [IDX_BITS-1:0] pend_idx;
   logic                pend_pred;
   logic [31:0]         pend_pc;

   logic                capture;
   logic                resolve;
   logic                mispredict;
   logic [1:0]          old_count;
   logic [1:0]          new_count;
   logic                unused_pc_bits;

   // Word-aligned PC bits select the entry; bits outside the index are unused.
   assign pc_idx         = pcID[IDX_BITS+1:2];
   assign unused_pc_bits = ^{pcID[31:IDX_BITS+2], pcID[1:0]};

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   assign lookup_idx = pc_idx ^ ghr;

   // Global history shifts in each resolved outcome unless flushed away.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ghr <= '0;
      end else if (resolve) begin
         ghr <= {ghr[IDX_BITS-2:0], actualEX};
      end
   end
`else
   assign lookup_idx = pc_idx;
`endif

   assign capture    = branchID & advance & ~flush;
   assign resolve    = pend_valid & ~flush;
   assign mispredict = resolve & (pend_pred != actualEX);

   assign taken      = branchID & counters[lookup_idx][1];
   assign needFlush  = mispredict;
   assign recoverPC  = mispredict ? (actualEX ? targetEX : pend_pc + 32'd4) : 32'd0;

   // Saturating increment/decrement of the counter owned by the EX branch.
   always_comb begin
      old_count = counters[pend_idx];
      new_count = old_count;
      if (actualEX) begin
         if (old_count != 2'b11) begin
            new_count = old_count + 2'd1;
         end
      end else begin
         if (old_count != 2'b00) begin
            new_count = old_count - 2'd1;
         end
      end
   end

   // Pending slot follows the branch from ID into EX; emptied when nothing advances.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pend_valid <= 1'b0;
         pend_idx   <= '0;
         pend_pred  <= 1'b0;
         pend_pc    <= 32'd0;
      end else if (capture) begin
         pend_valid <= 1'b1;
         pend_idx   <= lookup_idx;
         pend_pred  <= taken;
         pend_pc    <= pcID;
      end else begin
         pend_valid <= 1'b0;
         pend_idx   <= '0;
         pend_pred  <= 1'b0;
         pend_pc    <= 32'd0;
      end
   end

   // Counter table trains on every unflushed resolution, right or wrong.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            counters[i] <= INIT_STATE;
         end
      end else if (resolve) begin
         counters[pend_idx] <= new_count;
      end
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic conditional-branch predictor that sits directly upstream of the pipeline hazard unit. For a conditional branch in ID it supplies `taken`, used for speculative redirect. One cycle later, when that branch resolves in EX, it raises `needFlush` on a misprediction together with the correct recovery PC. Prediction uses a direct-mapped table of 2-bit saturating counters, indexed by PC and optionally hashed with global history.

## Interface
- `IDX_BITS`, 4, log2 of table entries (16 entries of 2 bits each).
- `INIT_STATE`, 2'b01, counter value loaded into every entry at reset (weakly not-taken).
- `Clk` input 1: single clock; all state updates on rising edge.
- `Rst` input 1: reset, asynchronous, active-low.
- `branchID` input 1: instruction in ID is a conditional branch (hazard unit `Branch[0]`).
- `pcID` input 32: PC of the instruction in ID.
- `advance` input 1: ID instruction moves to EX this cycle (no stall, no bubble).
- `flush` input 1: exception flush; discards any pending branch.
- `actualEX` input 1: resolved outcome of the branch now in EX (1 = taken).
- `targetEX` input 32: computed branch target of the branch in EX.
- `taken` output 1: prediction for the ID branch (to hazard unit `taken`).
- `needFlush` output 1: the branch in EX was mispredicted.
- `recoverPC` output 32: correct next PC when `needFlush` = 1; 0 otherwise.

## Operation
- Counter encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken. Prediction is counter bit 1.
- Lookup index: `idx = pcID[IDX_BITS+1:2]`, or the hashed form given under Configuration.
- `taken = branchID & table[idx][1]`. It is combinational and is 0 whenever `branchID` = 0.

Pending register, holding `pendValid`, `pendIdx`, `pendPred` and `pendPC`:
- Captures on the rising edge when `branchID & advance & !flush`.
- Is cleared on any other edge.

Resolution cycle, when `pendValid` = 1:
- `needFlush = pendValid & (pendPred != actualEX) & !flush`.
- `recoverPC = actualEX ? targetEX : pendPC + 4`, valid only while `needFlush` = 1.
- At the closing rising edge, `table[pendIdx]` updates:
  - `actualEX` = 1: increment, saturating at 11.
  - `actualEX` = 0: decrement, saturating at 00.
- The update happens even when the prediction was correct.
- The update is suppressed if `flush` = 1.

Other rules:
- Lookup and update of the same index in the same cycle: lookup returns the pre-update value. There is no bypass.
- Back-to-back branches: a new branch may be captured on the same edge that the previous one updates the table.
- When `pendValid` = 0, `actualEX` and `targetEX` are ignored.

## Timing
- Cycle N: branch in ID, `taken` valid combinationally in N.
- Cycle N+1: branch in EX, `needFlush` and `recoverPC` valid combinationally in N+1.
- End of cycle N+1: counter updated.
- Prediction latency: 0 cycles. Resolution latency: 1 cycle after capture.
- A branch stalled in ID (`advance` = 0) keeps re-predicting every cycle and is captured only on the cycle it advances.
- Reset values:
  - `Rst` low asynchronously clears `pendValid`, `pendIdx`, `pendPred`, `pendPC` and history to 0.
  - Every table entry is loaded with `INIT_STATE`.
  - Outputs read `taken` = 0 (with the default `INIT_STATE`), `needFlush` = 0, `recoverPC` = 0.
- Reset mid-resolution: the pending branch is dropped and no counter update occurs.

## Configuration
- `BP_GSHARE_EN` defined:
  - Adds an `IDX_BITS`-wide global history register, reset to 0.
  - Lookup index becomes `pcID[IDX_BITS+1:2] ^ ghr`.
  - `pendIdx` stores the hashed index, and the update uses it unchanged.
  - On each resolution edge without `flush`, `ghr <= {ghr[IDX_BITS-2:0], actualEX}`.
- `BP_GSHARE_EN` undefined:
  - No history register.
  - Index is the PC bits only.

## Test plan
- Reset, then `branchID` = 1, `pcID` = 0x00000040, `advance` = 1 -> `taken` = 0. Next cycle with `actualEX` = 1 and `targetEX` = 0x00000100 -> `needFlush` = 1, `recoverPC` = 0x00000100, entry 0 becomes 10.
- Same branch again, predicted taken, resolved `actualEX` = 0 -> `needFlush` = 1, `recoverPC` = 0x00000044, entry returns to 01.
- Four consecutive taken resolutions of PC 0x00000080 -> entry saturates at 11. A fifth taken resolution -> stays 11, `needFlush` = 0.
- `branchID` = 1 with `advance` = 0 for 3 cycles, then `advance` = 1 -> exactly one capture, exactly one update.
- Branch captured, then `flush` = 1 in the resolution cycle -> `needFlush` = 0, counter unchanged. `Rst` pulsed low mid-resolution -> pending dropped, all entries read 01.
- With `BP_GSHARE_EN` defined: after history 0001, `pcID` = 0x00000040 -> looks up index 1 rather than 0.
